// File: rtl/bip_pkg.sv
// Shared definitions for the BIP core slice.
//   - dbg_state_t : debug reporter FSM states
//   - FRAME_LEN   : bytes per debug frame
//   - DBG_HEADER  : first byte of every debug frame
//   - OP_*        : instruction opcodes decoded by Main
package bip_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } dbg_state_t;

  localparam int unsigned FRAME_LEN  = 7;
  localparam logic [7:0]  DBG_HEADER = 8'hA5;

  localparam logic [4:0] OP_HLT  = 5'd0;
  localparam logic [4:0] OP_STO  = 5'd1;
  localparam logic [4:0] OP_LD   = 5'd2;
  localparam logic [4:0] OP_LDI  = 5'd3;
  localparam logic [4:0] OP_ADD  = 5'd4;
  localparam logic [4:0] OP_ADDI = 5'd5;
  localparam logic [4:0] OP_SUB  = 5'd6;
  localparam logic [4:0] OP_SUBI = 5'd7;

endpackage

// File: rtl/bip_cycle_counter.sv
// Saturating, enable-gated cycle counter.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset (count -> 0)
//   en    : count this edge
//   count : current value, holds at all-ones once reached
module bip_cycle_counter #(
  parameter int unsigned CYC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CYC_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + CYC_W'(1);
    end
  end

endmodule

// File: rtl/bip_debug_tx.sv
// Halt-triggered debug reporter for the BIP Main core.
// Counts run cycles; on halt snapshots pc/acc/cycle count and streams a
// 7-byte frame (header, pc hi, pc lo, acc hi, acc lo, cyc hi, cyc lo) over a
// valid/ready byte interface.
//   clk      : clock, rising edge
//   rst_n    : synchronous active-low reset
//   pc       : program address from Main
//   acc      : accumulator from Main
//   halt     : level, high once Main executed HLT
//   tx_data  : frame byte (registered)
//   tx_valid : tx_data valid (registered)
//   tx_ready : sink accepts byte this edge
//   done     : frame fully sent, sticky until reset
module bip_debug_tx
  import bip_pkg::*;
#(
  parameter int unsigned PC_W   = 11,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CYC_W  = 16,
  parameter logic [7:0]  HEADER = DBG_HEADER
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PC_W-1:0]   pc,
  input  logic [DATA_W-1:0] acc,
  input  logic              halt,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              done
);

  localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

  dbg_state_t        state;
  logic [2:0]        idx;
  logic [PC_W-1:0]   pc_q;
  logic [DATA_W-1:0] acc_q;
  logic [CYC_W-1:0]  cyc_q;
  logic [CYC_W-1:0]  cyc;
  logic              cnt_en;

  // Counting stops on the capture edge itself and stays frozen afterwards.
  assign cnt_en = (state == ST_RUN) && !halt;

  bip_cycle_counter #(
    .CYC_W (CYC_W)
  ) u_cycle_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (cnt_en),
    .count (cyc)
  );

  // Fields are zero-extended to 16 bits so the upper pc byte carries
  // {5'b0, pc[10:8]} for the default 11-bit address.
  function automatic logic [7:0] frame_byte(
    input logic [2:0]        i,
    input logic [PC_W-1:0]   p,
    input logic [DATA_W-1:0] a,
    input logic [CYC_W-1:0]  c
  );
    logic [15:0] pw;
    logic [15:0] aw;
    logic [15:0] cw;
    pw = 16'(p);
    aw = 16'(a);
    cw = 16'(c);
    case (i)
      3'd0:    frame_byte = HEADER;
      3'd1:    frame_byte = pw[15:8];
      3'd2:    frame_byte = pw[7:0];
      3'd3:    frame_byte = aw[15:8];
      3'd4:    frame_byte = aw[7:0];
      3'd5:    frame_byte = cw[15:8];
      3'd6:    frame_byte = cw[7:0];
      default: frame_byte = '0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      idx      <= '0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      done     <= 1'b0;
      pc_q     <= '0;
      acc_q    <= '0;
      cyc_q    <= '0;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (halt) begin
            pc_q     <= pc;
            acc_q    <= acc;
            cyc_q    <= cyc;
            idx      <= '0;
            tx_data  <= HEADER;
            tx_valid <= 1'b1;
            state    <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (tx_ready) begin
            if (idx == LAST_IDX) begin
              state    <= ST_DONE;
              tx_valid <= 1'b0;
              tx_data  <= '0;
              done     <= 1'b1;
            end else begin
              // Next byte is preloaded so tx_data stays a registered output.
              idx     <= idx + 3'd1;
              tx_data <= frame_byte(idx + 3'd1, pc_q, acc_q, cyc_q);
            end
          end
        end
        ST_DONE: begin
          done <= 1'b1;
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bip_debug_tx.sv
module tb_bip_debug_tx;

  logic        clk;
  logic        rst_n;
  logic [10:0] pc;
  logic [15:0] acc;
  logic        halt;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        done;

  int checks = 0;
  int errors = 0;
  logic [7:0] q[$];

  bip_debug_tx #(
    .PC_W   (11),
    .DATA_W (16),
    .CYC_W  (16),
    .HEADER (8'hA5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pc       (pc),
    .acc      (acc),
    .halt     (halt),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [10:0] p, input logic [15:0] a, input logic [15:0] c);
    q.push_back(8'hA5);
    q.push_back({5'b0, p[10:8]});
    q.push_back(p[7:0]);
    q.push_back(a[15:8]);
    q.push_back(a[7:0]);
    q.push_back(c[15:8]);
    q.push_back(c[7:0]);
  endtask

  // Leaves rst_n released with no edge taken since release.
  task automatic apply_reset(input logic h);
    rst_n    = 1'b0;
    halt     = h;
    tx_ready = 1'b0;
    q.delete();
    tick();
    tick();
    chk("rst_valid", tx_valid, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_data", tx_data, 8'h00);
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    halt = 1'b0;
    repeat (n) tick();
  endtask

  task automatic halt_frame(input logic [10:0] p, input logic [15:0] a, input logic [15:0] c);
    pc       = p;
    acc      = a;
    halt     = 1'b1;
    tx_ready = 1'b1;
    push_frame(p, a, c);
    tick();
    chk("latency_valid", tx_valid, 1'b1);
    chk("latency_hdr", tx_data, 8'hA5);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 50) begin
      tick();
      n++;
    end
    chk("done_set", done, 1'b1);
    chk("queue_drained", q.size(), 0);
    // DONE is terminal regardless of halt/tx_ready activity.
    for (int i = 0; i < 3; i++) begin
      halt     = ~halt;
      tx_ready = ~tx_ready;
      tick();
      chk("done_hold", done, 1'b1);
      chk("done_valid_low", tx_valid, 1'b0);
    end
  endtask

  // Monitor: samples on the falling edge, between stimulus updates.
  initial begin
    logic [7:0] tmp;
    forever begin
      @(negedge clk);
      if (rst_n && tx_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %0h expected no byte at %0t", tx_data, $time);
        end else if (tx_ready) begin
          chk("frame_byte", tx_data, q[0]);
          tmp = q.pop_front();
          if (q.size() == 0) begin
            @(posedge clk);
            #1;
            chk("done_after_last", done, 1'b1);
            chk("valid_after_last", tx_valid, 1'b0);
          end
        end else begin
          chk("stall_hold", tx_data, q[0]);
        end
      end
    end
  end

  initial begin
    int n;
    rst_n = 1'b0; halt = 1'b0; pc = '0; acc = '0; tx_ready = 1'b0;

    // Basic frame, ready always high.
    apply_reset(1'b0);
    idle(10);
    halt_frame(11'h123, 16'hBEEF, 16'd10);
    wait_done(n);
    chk("t1_cycles", n, 7);

    // Backpressure for 3 cycles at idx 2.
    apply_reset(1'b0);
    idle(10);
    halt_frame(11'h123, 16'hBEEF, 16'd10);
    tick();
    tick();
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t2_stall_valid", tx_valid, 1'b1);
      chk("t2_stall_data", tx_data, 8'h23);
      tick();
    end
    tx_ready = 1'b1;
    wait_done(n);
    chk("t2_remaining", n, 5);

    // Inputs change and halt drops mid-frame, with ready toggling.
    apply_reset(1'b0);
    idle(3);
    halt_frame(11'h7FF, 16'h1234, 16'd3);
    pc   = 11'h000;
    acc  = 16'h0000;
    halt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tx_ready = i[0];
      tick();
    end
    tx_ready = 1'b1;
    wait_done(n);

    // Reset after the 3rd handshake aborts; fresh frame afterwards.
    apply_reset(1'b0);
    idle(4);
    halt_frame(11'h456, 16'h00FF, 16'd4);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    halt  = 1'b0;
    q.delete();
    tick();
    chk("t5_abort_valid", tx_valid, 1'b0);
    chk("t5_abort_done", done, 1'b0);
    rst_n = 1'b1;
    idle(5);
    halt_frame(11'h2AB, 16'h00FF, 16'd5);
    wait_done(n);

    // Halt already high across reset release.
    apply_reset(1'b1);
    halt_frame(11'h0AA, 16'h5A5A, 16'd0);
    wait_done(n);
    chk("t6_cycles", n, 7);

    // Counter saturation.
    apply_reset(1'b0);
    idle(70000);
    halt_frame(11'h000, 16'h0000, 16'hFFFF);
    wait_done(n);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
